// File: rtl/reorder_buf_pkg.sv
// Shared constants, FSM encoding and the 11-bit digit-reversal map
// used by the 2048-point reorder buffer.
package reorder_buf_pkg;

    localparam int RE_ADDR_W = 11;
    localparam int RE_DEPTH  = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Digits (hi4, mid4, lo3) of k swapped end for end.
    function automatic logic [RE_ADDR_W-1:0] digit_rev11(
        input logic [RE_ADDR_W-1:0] k
    );
        return {k[2:0], k[6:3], k[10:7]};
    endfunction

endpackage

// File: rtl/reorder_buf_if.sv
// Write-side strobe bus and read-side valid/ready stream of the
// reorder buffer; slave is the buffer's view.
interface reorder_buf_if
    import reorder_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = RE_ADDR_W
);

    logic [ADDR_WIDTH-1:0] REMA;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  done;
    logic                  wr_ovf;

    modport master (
        output REMA, wr_en, data_in, out_ready,
        input  data_out, out_valid, out_index, done, wr_ovf
    );

    modport slave (
        input  REMA, wr_en, data_in, out_ready,
        output data_out, out_valid, out_index, done, wr_ovf
    );

endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port frame RAM: one write port, one registered read
// port. The array is never reset; only the read register is.
module reorder_ram #(
    parameter int DW    = 64,
    parameter int AW    = 11,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the output data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/reorder_buf.sv
// Captures one FFT frame at counter-supplied addresses, then streams
// it out in digit-reversed order over a valid/ready port.
module reorder_buf
    import reorder_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = RE_ADDR_W,
    parameter int DEPTH      = RE_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    reorder_buf_if.slave  io
);

    localparam int CW = ADDR_WIDTH + 1;

    state_t                state;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic                  rd_arm;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_index_q;
    logic                  done_q;
    logic                  wr_ovf_q;

    logic wr_acc;
    logic accept;
    logic issue;

    assign wr_acc = io.wr_en && (state == IDLE || state == FILL);
    assign accept = out_valid_q && io.out_ready;
    assign issue  = (state == DRAIN) && rd_arm
                 && (rd_cnt < CW'(DEPTH))
                 && (!out_valid_q || io.out_ready);

    reorder_ram #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (io.REMA),
        .wdata (io.data_in),
        .re    (issue),
        .raddr (digit_rev11(rd_cnt[ADDR_WIDTH-1:0])),
        .rdata (io.data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            rd_arm      <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            done_q      <= 1'b0;
            wr_ovf_q    <= 1'b0;
        end else begin
            // First read waits one cycle after the completing write.
            rd_arm <= (state == DRAIN);

            if (wr_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (io.wr_en && !wr_acc) begin
                wr_ovf_q <= 1'b1;
            end

            if (issue) begin
                out_valid_q <= 1'b1;
                out_index_q <= rd_cnt[ADDR_WIDTH-1:0];
                rd_cnt      <= rd_cnt + 1'b1;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (wr_acc) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (wr_acc && wr_cnt == CW'(DEPTH - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept
                        && out_index_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_index = out_index_q;
    assign io.done      = done_q;
    assign io.wr_ovf    = wr_ovf_q;

endmodule

// File: tb/tb_reorder_buf.sv
// Directed bench for reorder_buf: fill/drain ordering, backpressure,
// overflow stickiness and asynchronous reset in FILL and DRAIN.
module tb_reorder_buf;

    logic clk;
    logic rst_n;

    reorder_buf_if #(.DATA_WIDTH(64), .ADDR_WIDTH(11)) io();

    reorder_buf #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (11),
        .DEPTH      (2048)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int perm [2048];
    logic [63:0] seen [2048];

    function automatic logic [63:0] drev(input int k);
        return 64'(((k % 8) * 256) + (((k / 8) % 16) * 16) + (k / 128));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        io.wr_en = 1'b0;
        io.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic seq_perm();
        for (int i = 0; i < 2048; i++) perm[i] = i;
    endtask

    task automatic shuffle_perm();
        int j;
        int t;
        seq_perm();
        for (int i = 2047; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [63:0] off);
        for (int i = lo; i < hi; i++) begin
            io.wr_en = 1'b1;
            io.REMA = 11'(perm[i]);
            io.data_in = 64'(perm[i]) + off;
            tick();
        end
        io.wr_en = 1'b0;
    endtask

    // Called just after the 2048th write edge t.
    task automatic check_start(input string tag);
        chk({tag, "_valid_t"}, 64'(io.out_valid), 64'd0);
        tick();
        chk({tag, "_valid_t1"}, 64'(io.out_valid), 64'd0);
        tick();
        chk({tag, "_valid_t2"}, 64'(io.out_valid), 64'd1);
        chk({tag, "_index_t2"}, 64'(io.out_index), 64'd0);
    endtask

    task automatic drain(input int pct, input logic [63:0] off,
                         input int stop_at, input bit inj,
                         output int gaps);
        int k;
        int cyc;
        bit stall;
        logic [63:0] hd;
        logic [10:0] hi;
        k = 0;
        cyc = 0;
        stall = 0;
        gaps = 0;
        hd = '0;
        hi = '0;
        while (k < 2048 && cyc < 40000) begin
            if (stall) begin
                chk("hold_data", io.data_out, hd);
                chk("hold_index", 64'(io.out_index), 64'(hi));
            end
            if (stop_at >= 0 && io.out_valid
                && int'(io.out_index) == stop_at) begin
                return;
            end
            io.out_ready = (int'($urandom_range(0, 99)) < pct);
            io.wr_en = inj && (cyc % 50 == 3);
            io.REMA = 11'($urandom_range(0, 2047));
            io.data_in = 64'hBAD0_0000_0000_0000 | 64'(cyc);
            if (!io.out_valid) begin
                gaps++;
            end else if (io.out_ready) begin
                chk("out_index", 64'(io.out_index), 64'(k));
                chk("out_data", io.data_out, drev(k) + off);
                seen[k] = io.data_out;
                if (k == 2047) chk("done_early", 64'(io.done), 64'd0);
                k++;
            end
            stall = io.out_valid && !io.out_ready;
            hd = io.data_out;
            hi = io.out_index;
            tick();
            cyc++;
        end
        io.wr_en = 1'b0;
        chk("drain_count", 64'(k), 64'd2048);
    endtask

    initial begin
        int gaps;
        rst_n = 1'b0;
        io.wr_en = 1'b0;
        io.REMA = '0;
        io.data_in = '0;
        io.out_ready = 1'b0;
        #1;
        chk("rst_valid", 64'(io.out_valid), 64'd0);
        chk("rst_data", io.data_out, 64'd0);
        chk("rst_index", 64'(io.out_index), 64'd0);
        chk("rst_done", 64'(io.done), 64'd0);
        chk("rst_ovf", 64'(io.wr_ovf), 64'd0);
        do_reset();

        // Sequential fill, full-rate drain
        seq_perm();
        io.out_ready = 1'b1;
        fill(0, 2048, 64'd0);
        check_start("seq");
        drain(100, 64'd0, -1, 1'b0, gaps);
        chk("seq_gaps", 64'(gaps), 64'd0);
        chk("seq_done", 64'(io.done), 64'd1);
        chk("seq_valid_end", 64'(io.out_valid), 64'd0);
        chk("seq_ovf", 64'(io.wr_ovf), 64'd0);
        chk("seq_k0", seen[0], 64'd0);
        chk("seq_k1", seen[1], 64'd256);
        chk("seq_k8", seen[8], 64'd16);
        chk("seq_k128", seen[128], 64'd1);
        chk("seq_k2047", seen[2047], 64'd2047);
        tick();
        chk("seq_done_sticky", 64'(io.done), 64'd1);

        // Write after DONE
        io.wr_en = 1'b1;
        io.REMA = 11'd3;
        tick();
        io.wr_en = 1'b0;
        chk("done_ovf", 64'(io.wr_ovf), 64'd1);
        tick();
        chk("done_ovf_sticky", 64'(io.wr_ovf), 64'd1);

        // Scrambled fill, 30% ready, writes injected during DRAIN
        do_reset();
        chk("scr_ovf_clear", 64'(io.wr_ovf), 64'd0);
        shuffle_perm();
        fill(0, 2048, 64'd0);
        check_start("scr");
        drain(30, 64'd0, -1, 1'b1, gaps);
        chk("scr_ovf", 64'(io.wr_ovf), 64'd1);
        chk("scr_done", 64'(io.done), 64'd1);
        io.wr_en = 1'b1;
        tick();
        io.wr_en = 1'b0;
        tick();
        chk("scr_ovf_sticky", 64'(io.wr_ovf), 64'd1);
        chk("scr_done_sticky", 64'(io.done), 64'd1);

        // Reset in the middle of DRAIN
        do_reset();
        seq_perm();
        fill(0, 2048, 64'd0);
        check_start("mid");
        drain(100, 64'd0, 700, 1'b0, gaps);
        chk("mid_at_700", 64'(io.out_index), 64'd700);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(io.out_valid), 64'd0);
        chk("mid_rst_data", io.data_out, 64'd0);
        chk("mid_rst_index", 64'(io.out_index), 64'd0);
        chk("mid_rst_done", 64'(io.done), 64'd0);
        do_reset();
        fill(0, 2048, 64'd5);
        check_start("mid2");
        drain(100, 64'd5, -1, 1'b0, gaps);
        chk("mid2_done", 64'(io.done), 64'd1);

        // Reset during FILL after 1000 writes
        do_reset();
        shuffle_perm();
        fill(0, 1000, 64'h77);
        rst_n = 1'b0;
        #1;
        chk("fill_rst_valid", 64'(io.out_valid), 64'd0);
        do_reset();
        fill(0, 2047, 64'd9);
        for (int i = 0; i < 4; i++) begin
            chk("fill_partial_valid", 64'(io.out_valid), 64'd0);
            tick();
        end
        fill(2047, 2048, 64'd9);
        check_start("refill");
        drain(100, 64'd9, -1, 1'b0, gaps);
        chk("refill_done", 64'(io.done), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
